sprite_layer_engine: RTL and testbench

// - Multi-sprite pixel engine; successor to the single-sprite ROM wrapper, generalised to N_SPR channels.
// - Per beam pixel (x,y): hit-test every sprite, drive per-channel ROM addresses and mux the returned colours.
// - Adds priority, colour-key transparency, per-sprite enable/h-flip, tear-free position latching and a sprite-0 collision flag.
// - Sits between the VGA timing generator and the final RGB mux; sprite ROMs are external (1-cycle synchronous read).

---
 rtl/sprite_layer_engine_pkg.sv | 7 +
 rtl/sprite_layer_engine_if.sv | 15 +
 rtl/sprite_layer_engine_hit_chan.sv | 88 ++++++++
 rtl/sprite_layer_engine.sv | 95 +++++++++
 tb/tb_sprite_layer_engine.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_layer_engine_pkg.sv
// Shared widths and pipeline constants for the multi-sprite layer engine.
package sprite_layer_engine_pkg;
  localparam int LATENCY = 3;
  localparam int POS_W   = 11;
  localparam int BEAM_W  = 10;
  localparam int DIFF_W  = 12;
endpackage

// File: rtl/sprite_layer_engine_if.sv
// Sprite ROM bus: per-channel row/column address out, colour data back.
// Handshake: no valid/ready; the ROM always accepts an address and returns its word one cycle later.
interface sprite_layer_engine_if #(
  parameter int N_SPR = 4,
  parameter int ROW_W = 8,
  parameter int COL_W = 7,
  parameter int RGB_W = 12
);
  logic [N_SPR*ROW_W-1:0] rom_row;
  logic [N_SPR*COL_W-1:0] rom_col;
  logic [N_SPR*RGB_W-1:0] rom_data;

  modport master (output rom_row, output rom_col, input rom_data);
  modport slave  (input rom_row, input rom_col, output rom_data);
endinterface

// File: rtl/sprite_layer_engine_hit_chan.sv
// One sprite channel: frame-latched attributes, hit test with h-flip, ROM address
// stage and a hit bit delayed to line up with the returned ROM word.
module sprite_hit_chan
  import sprite_layer_engine_pkg::*;
#(
  parameter int SPR_W = 100,
  parameter int SPR_H = 200,
  parameter int COL_W = 7,
  parameter int ROW_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [BEAM_W-1:0] x,
  input  logic [BEAM_W-1:0] y,
  input  logic [POS_W-1:0]  pos_x,
  input  logic [POS_W-1:0]  pos_y,
  input  logic              en,
  input  logic              flip,
  output logic [ROW_W-1:0]  rom_row,
  output logic [COL_W-1:0]  rom_col,
  output logic              hit_s2
);
  localparam logic signed [DIFF_W-1:0] W_S   = DIFF_W'(SPR_W);
  localparam logic signed [DIFF_W-1:0] H_S   = DIFF_W'(SPR_H);
  localparam logic signed [DIFF_W-1:0] W_M1  = DIFF_W'(SPR_W - 1);

  logic [POS_W-1:0] spos_x_q, spos_x_d, spos_y_q, spos_y_d;
  logic             sen_q, sen_d, sflip_q, sflip_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d;
  logic signed [DIFF_W-1:0] dx, dy;
  logic             hit;

  always_comb begin
    spos_x_d = spos_x_q;
    spos_y_d = spos_y_q;
    sen_d    = sen_q;
    sflip_d  = sflip_q;
    if (frame_start) begin
      spos_x_d = pos_x;
      spos_y_d = pos_y;
      sen_d    = en;
      sflip_d  = flip;
    end

    // One extra bit of headroom keeps beam minus signed position from wrapping.
    dx  = $signed({2'b00, x}) - $signed({spos_x_q[POS_W-1], spos_x_q});
    dy  = $signed({2'b00, y}) - $signed({spos_y_q[POS_W-1], spos_y_q});
    hit = sen_q && !dx[DIFF_W-1] && (dx < W_S) && !dy[DIFF_W-1] && (dy < H_S);

    hit_s1_d = hit;
    row_d    = '0;
    col_d    = '0;
    if (hit) begin
      row_d = ROW_W'(dy);
      col_d = sflip_q ? COL_W'(W_M1 - dx) : COL_W'(dx);
    end
    hit_s2_d = hit_s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spos_x_q <= '0;
      spos_y_q <= '0;
      sen_q    <= 1'b0;
      sflip_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      hit_s1_q <= 1'b0;
      hit_s2_q <= 1'b0;
    end else begin
      spos_x_q <= spos_x_d;
      spos_y_q <= spos_y_d;
      sen_q    <= sen_d;
      sflip_q  <= sflip_d;
      row_q    <= row_d;
      col_q    <= col_d;
      hit_s1_q <= hit_s1_d;
      hit_s2_q <= hit_s2_d;
    end
  end

  assign rom_row = row_q;
  assign rom_col = col_q;
  assign hit_s2  = hit_s2_q;
endmodule

// File: rtl/sprite_layer_engine.sv
// Multi-sprite pixel engine: N_SPR hit-test channels feeding a priority compositor
// with colour-key transparency and a sticky sprite-0 collision flag.
module sprite_layer_engine
  import sprite_layer_engine_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int SPR_W = 100,
  parameter int SPR_H = 200,
  parameter int COL_W = 7,
  parameter int ROW_W = 8,
  parameter int RGB_W = 12,
  parameter logic [RGB_W-1:0] KEY = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [BEAM_W-1:0]      x,
  input  logic [BEAM_W-1:0]      y,
  input  logic [N_SPR*POS_W-1:0] pos_x,
  input  logic [N_SPR*POS_W-1:0] pos_y,
  input  logic [N_SPR-1:0]       spr_en,
  input  logic [N_SPR-1:0]       spr_flip,
  sprite_layer_engine_if.master  rom,
  output logic [RGB_W-1:0]       rgb,
  output logic                   sprite_on,
  output logic                   collide
);
  logic [ROW_W-1:0] row_ch [N_SPR];
  logic [COL_W-1:0] col_ch [N_SPR];
  logic [N_SPR-1:0] hit_s2, opaque;
  logic             others;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             sprite_on_q, sprite_on_d, collide_q, collide_d;

  for (genvar i = 0; i < N_SPR; i++) begin : g_chan
    sprite_hit_chan #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .x          (x),
      .y          (y),
      .pos_x      (pos_x[POS_W*i +: POS_W]),
      .pos_y      (pos_y[POS_W*i +: POS_W]),
      .en         (spr_en[i]),
      .flip       (spr_flip[i]),
      .rom_row    (row_ch[i]),
      .rom_col    (col_ch[i]),
      .hit_s2     (hit_s2[i])
    );
  end

  always_comb begin
    rom.rom_row = '0;
    rom.rom_col = '0;
    for (int i = 0; i < N_SPR; i++) begin
      rom.rom_row[ROW_W*i +: ROW_W] = row_ch[i];
      rom.rom_col[COL_W*i +: COL_W] = col_ch[i];
    end
  end

  always_comb begin
    opaque = '0;
    others = 1'b0;
    rgb_d  = '0;
    // Walk from lowest priority up so the lowest-index opaque channel is written last.
    for (int i = N_SPR - 1; i >= 0; i--) begin
      opaque[i] = hit_s2[i] && (rom.rom_data[RGB_W*i +: RGB_W] != KEY);
      if (opaque[i]) rgb_d = rom.rom_data[RGB_W*i +: RGB_W];
    end
    for (int i = 1; i < N_SPR; i++) others = others | opaque[i];
    sprite_on_d = |opaque;

    collide_d = collide_q;
    if (opaque[0] && others) collide_d = 1'b1;
    if (frame_start)         collide_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q       <= '0;
      sprite_on_q <= 1'b0;
      collide_q   <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      sprite_on_q <= sprite_on_d;
      collide_q   <= collide_d;
    end
  end

  assign rgb       = rgb_q;
  assign sprite_on = sprite_on_q;
  assign collide   = collide_q;
endmodule

// File: tb/tb_sprite_layer_engine.sv
// Bench for sprite_layer_engine: directed vectors and sequences plus random beam
// traffic checked every cycle against a pixel-level reference model.
module tb_sprite_layer_engine;
  import sprite_layer_engine_pkg::*;

  localparam int N = 4;
  localparam int IDLE_X = 600;
  localparam int IDLE_Y = 500;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [9:0]  x, y;
  logic [43:0] pos_x, pos_y;
  logic [3:0]  spr_en, spr_flip;
  logic [11:0] rgb;
  logic        sprite_on, collide;

  sprite_layer_engine_if #(.N_SPR(N), .ROW_W(8), .COL_W(7), .RGB_W(12)) rom_if ();

  sprite_layer_engine dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .x(x), .y(y),
    .pos_x(pos_x), .pos_y(pos_y), .spr_en(spr_en), .spr_flip(spr_flip),
    .rom(rom_if), .rgb(rgb), .sprite_on(sprite_on), .collide(collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ROM contents: every 7th diagonal is transparent, otherwise channel-tagged colour.
  bit          force_en  [N];
  logic [11:0] force_val [N];

  function automatic logic [11:0] rom_fn(int ch, int row, int col);
    if (force_en[ch]) return force_val[ch];
    if ((row + col + ch) % 7 == 0) return 12'h000;
    return 12'((ch + 1) * 256 + (row % 16) * 16 + (col % 16));
  endfunction

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      rom_if.rom_data[12*i +: 12] <= rom_fn(i, int'(rom_if.rom_row[8*i +: 8]), int'(rom_if.rom_col[7*i +: 7]));

  // Reference model state: latched attributes, addressed pixel, composited pixel, outputs.
  int          sh_px [N], sh_py [N];
  bit          sh_en [N], sh_flip [N];
  bit          m_hit [N];
  int          m_row [N], m_col [N];
  logic [11:0] m_s2_rgb, m_rgb;
  bit          m_s2_on, m_s2_coll, m_on, m_coll;

  task automatic model_step();
    logic [11:0] d;
    bit op [N];
    int dx, dy;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sh_px[i] = 0; sh_py[i] = 0; sh_en[i] = 0; sh_flip[i] = 0;
        m_hit[i] = 0; m_row[i] = 0; m_col[i] = 0;
      end
      m_s2_rgb = 0; m_s2_on = 0; m_s2_coll = 0;
      m_rgb = 0; m_on = 0; m_coll = 0;
    end else begin
      m_rgb = m_s2_rgb;
      m_on  = m_s2_on;
      if (frame_start) m_coll = 0;
      else if (m_s2_coll) m_coll = 1;

      m_s2_rgb = 0;
      m_s2_on  = 0;
      for (int i = 0; i < N; i++) begin
        d = rom_fn(i, m_row[i], m_col[i]);
        op[i] = m_hit[i] && (d != 12'h000);
        if (op[i] && !m_s2_on) m_s2_rgb = d;
        if (op[i]) m_s2_on = 1;
      end
      m_s2_coll = op[0] && (op[1] || op[2] || op[3]);

      for (int i = 0; i < N; i++) begin
        dx = int'(x) - sh_px[i];
        dy = int'(y) - sh_py[i];
        m_hit[i] = sh_en[i] && dx >= 0 && dx < 100 && dy >= 0 && dy < 200;
        m_row[i] = m_hit[i] ? dy : 0;
        m_col[i] = m_hit[i] ? (sh_flip[i] ? 99 - dx : dx) : 0;
      end

      if (frame_start)
        for (int i = 0; i < N; i++) begin
          sh_px[i]   = $signed(pos_x[11*i +: 11]);
          sh_py[i]   = $signed(pos_y[11*i +: 11]);
          sh_en[i]   = spr_en[i];
          sh_flip[i] = spr_flip[i];
        end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] er, ec;
    er = '0; ec = '0;
    for (int i = 0; i < N; i++) begin
      er[8*i +: 8] = m_row[i][7:0];
      ec[7*i +: 7] = m_col[i][6:0];
    end
    check("model rgb", 32'(rgb), 32'(m_rgb));
    check("model sprite_on", 32'(sprite_on), 32'(m_on));
    check("model collide", 32'(collide), 32'(m_coll));
    check("model rom_row", 32'(rom_if.rom_row), er);
    check("model rom_col", 32'(rom_if.rom_col), ec);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic pix(int px, int py);
    x = 10'(px);
    y = 10'(py);
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) pix(IDLE_X, IDLE_Y);
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1;
    pix(IDLE_X, IDLE_Y);
    frame_start = 1'b0;
  endtask

  task automatic set_spr(int i, int px, int py, bit e, bit f);
    pos_x[11*i +: 11] = px[10:0];
    pos_y[11*i +: 11] = py[10:0];
    spr_en[i]   = e;
    spr_flip[i] = f;
  endtask

  typedef struct packed {
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic               flip;
    logic [9:0]         x;
    logic [9:0]         y;
    logic               on;
    logic [7:0]         row;
    logic [6:0]         col;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{12'sd10,  12'sd20,  1'b0, 10'd9,    10'd20,  1'b0, 8'd0,   7'd0};
    vecs[1]  = '{12'sd10,  12'sd20,  1'b0, 10'd10,   10'd20,  1'b1, 8'd0,   7'd0};
    vecs[2]  = '{12'sd10,  12'sd20,  1'b0, 10'd109,  10'd25,  1'b1, 8'd5,   7'd99};
    vecs[3]  = '{12'sd10,  12'sd20,  1'b0, 10'd110,  10'd20,  1'b0, 8'd0,   7'd0};
    vecs[4]  = '{12'sd10,  12'sd20,  1'b1, 10'd10,   10'd20,  1'b1, 8'd0,   7'd99};
    vecs[5]  = '{12'sd10,  12'sd20,  1'b1, 10'd109,  10'd20,  1'b1, 8'd0,   7'd0};
    vecs[6]  = '{-12'sd50, 12'sd20,  1'b0, 10'd0,    10'd20,  1'b1, 8'd0,   7'd50};
    vecs[7]  = '{12'sd1000,12'sd20,  1'b0, 10'd1023, 10'd20,  1'b1, 8'd0,   7'd23};
    vecs[8]  = '{12'sd10,  12'sd20,  1'b0, 10'd50,   10'd219, 1'b1, 8'd199, 7'd40};
    vecs[9]  = '{12'sd10,  12'sd20,  1'b0, 10'd50,   10'd220, 1'b0, 8'd0,   7'd0};
    vecs[10] = '{12'sd10,  12'sd20,  1'b0, 10'd50,   10'd19,  1'b0, 8'd0,   7'd0};
    vecs[11] = '{-12'sd50, -12'sd10, 1'b0, 10'd49,   10'd0,   1'b1, 8'd10,  7'd99};

    reset = 1'b1; frame_start = 1'b0; x = '0; y = '0;
    pos_x = '0; pos_y = '0; spr_en = '0; spr_flip = '0;
    for (int i = 0; i < N; i++) begin force_en[i] = 0; force_val[i] = '0; end
    tick(); tick();
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset sprite_on", 32'(sprite_on), 32'h0);
    check("reset collide", 32'(collide), 32'h0);
    check("reset rom_row", 32'(rom_if.rom_row), 32'h0);
    reset = 1'b0;

    // Attributes set but never latched: nothing drawn.
    force_en[0] = 1; force_val[0] = 12'hF00;
    set_spr(0, 10, 20, 1, 0);
    repeat (LATENCY) pix(10, 20);
    check("no latch sprite_on", 32'(sprite_on), 32'h0);
    fs_pulse();
    pix(10, 20);
    check("first rom_row", 32'(rom_if.rom_row[7:0]), 32'h0);
    check("first rom_col", 32'(rom_if.rom_col[6:0]), 32'h0);
    idle(LATENCY - 1);
    check("first sprite_on", 32'(sprite_on), 32'h1);
    check("first rgb", 32'(rgb), 32'hF00);

    force_val[0] = 12'h123;
    foreach (vecs[k]) begin
      set_spr(0, int'(vecs[k].px), int'(vecs[k].py), 1, vecs[k].flip);
      fs_pulse();
      pix(int'(vecs[k].x), int'(vecs[k].y));
      check($sformatf("vec%0d rom_row", k), 32'(rom_if.rom_row[7:0]), 32'(vecs[k].row));
      check($sformatf("vec%0d rom_col", k), 32'(rom_if.rom_col[6:0]), 32'(vecs[k].col));
      idle(LATENCY - 1);
      check($sformatf("vec%0d sprite_on", k), 32'(sprite_on), 32'(vecs[k].on));
    end

    // Priority with a keyed-out top sprite, then both opaque.
    set_spr(0, 10, 20, 1, 0);
    set_spr(1, 10, 20, 1, 0);
    force_en[1] = 1; force_val[1] = 12'h0F0; force_val[0] = 12'h000;
    fs_pulse();
    pix(15, 25); idle(LATENCY - 1);
    check("key reveals rgb", 32'(rgb), 32'h0F0);
    check("key no collide", 32'(collide), 32'h0);
    force_val[0] = 12'hF00;
    pix(15, 25); idle(LATENCY - 1);
    check("prio rgb", 32'(rgb), 32'hF00);
    check("prio collide set", 32'(collide), 32'h1);
    idle(2);
    check("collide held", 32'(collide), 32'h1);
    fs_pulse();
    check("collide cleared", 32'(collide), 32'h0);
    pix(15, 25); idle(LATENCY - 2);
    frame_start = 1'b1;
    pix(IDLE_X, IDLE_Y);
    frame_start = 1'b0;
    check("set/clear clear wins", 32'(collide), 32'h0);
    idle(1);
    check("collide stays clear", 32'(collide), 32'h0);

    // Mid-line reset drops outputs and attributes.
    repeat (LATENCY) pix(15, 25);
    check("pre-reset sprite_on", 32'(sprite_on), 32'h1);
    reset = 1'b1;
    pix(15, 25);
    reset = 1'b0;
    check("mid reset rgb", 32'(rgb), 32'h0);
    check("mid reset sprite_on", 32'(sprite_on), 32'h0);
    check("mid reset collide", 32'(collide), 32'h0);
    repeat (LATENCY + 1) pix(15, 25);
    check("post reset no draw", 32'(sprite_on), 32'h0);
    fs_pulse();
    repeat (LATENCY) pix(15, 25);
    check("redraw after fs", 32'(sprite_on), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < N; i++) force_en[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      frame_start = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (frame_start)
        for (int i = 0; i < N; i++)
          set_spr(i, int'($urandom_range(0, 400)) - 100, int'($urandom_range(0, 400)) - 100,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      pix(int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
    end
    frame_start = 1'b0;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
